id_ex_ctrl_pipe: RTL and testbench

- Pipelined successor to the single-cycle control unit.
- Decodes an RV32I instruction into the existing control bundle and holds it, with pc/instr/register indices, in an ID/EX register under valid/ready handshake.
- Adds load-use hazard detection with bubble insertion, synchronous flush, illegal-opcode flagging, and saturating stall/flush performance counters.
- Sits between fetch and execute in the pipelined core.

---
 rtl/id_ex_ctrl_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX stage: decodes an RV32I instruction into the control bundle and registers it
// behind a valid/ready handshake with load-use interlock, flush and perf counters.
module id_ex_ctrl_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             reg_write,
  output logic             operand_a,
  output logic             operand_b,
  output logic             load,
  output logic             store,
  output logic             branch,
  output logic             mem_en,
  output logic             next_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       mem_to_reg,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluPass = 4'b1111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign in_rs1 = instr[19:15];
  assign in_rs2 = instr[24:20];

  logic       d_reg_write, d_operand_a, d_operand_b, d_load, d_store, d_branch;
  logic       d_mem_en, d_next_sel, d_illegal, d_uses_rs1, d_uses_rs2;
  logic [2:0] d_imm_sel;
  logic [1:0] d_mem_to_reg;
  logic [3:0] d_alu_control;

  always_comb begin
    d_reg_write   = 1'b0;
    d_operand_a   = 1'b0;
    d_operand_b   = 1'b0;
    d_load        = 1'b0;
    d_store       = 1'b0;
    d_branch      = 1'b0;
    d_mem_en      = 1'b0;
    d_next_sel    = 1'b0;
    d_illegal     = 1'b0;
    d_uses_rs1    = 1'b0;
    d_uses_rs2    = 1'b0;
    d_imm_sel     = ImmI;
    d_mem_to_reg  = 2'd0;
    d_alu_control = AluAdd;
    unique case (opcode)
      OpR: begin
        d_reg_write   = 1'b1;
        d_uses_rs1    = 1'b1;
        d_uses_rs2    = 1'b1;
        d_alu_control = {instr[30], funct3};
      end
      OpI: begin
        d_reg_write   = 1'b1;
        d_operand_b   = 1'b1;
        d_uses_rs1    = 1'b1;
        // instr[30] only distinguishes srai from srli; for other ops it is immediate data
        d_alu_control = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
      end
      OpLoad: begin
        d_reg_write  = 1'b1;
        d_operand_b  = 1'b1;
        d_load       = 1'b1;
        d_mem_en     = 1'b1;
        d_uses_rs1   = 1'b1;
        d_mem_to_reg = 2'd1;
      end
      OpStore: begin
        d_operand_b = 1'b1;
        d_store     = 1'b1;
        d_mem_en    = 1'b1;
        d_uses_rs1  = 1'b1;
        d_uses_rs2  = 1'b1;
        d_imm_sel   = ImmS;
      end
      OpBranch: begin
        d_branch      = 1'b1;
        d_uses_rs1    = 1'b1;
        d_uses_rs2    = 1'b1;
        d_imm_sel     = ImmB;
        d_alu_control = AluSub;
      end
      OpJal: begin
        d_reg_write  = 1'b1;
        d_operand_a  = 1'b1;
        d_operand_b  = 1'b1;
        d_next_sel   = 1'b1;
        d_imm_sel    = ImmJ;
        d_mem_to_reg = 2'd2;
      end
      OpJalr: begin
        d_reg_write  = 1'b1;
        d_operand_b  = 1'b1;
        d_next_sel   = 1'b1;
        d_uses_rs1   = 1'b1;
        d_mem_to_reg = 2'd2;
      end
      OpLui: begin
        d_reg_write   = 1'b1;
        d_operand_b   = 1'b1;
        d_imm_sel     = ImmU;
        d_alu_control = AluPass;
      end
      OpAuipc: begin
        d_reg_write = 1'b1;
        d_operand_a = 1'b1;
        d_operand_b = 1'b1;
        d_imm_sel   = ImmU;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic adv;
  logic raw_hazard;

  // The held bundle is a load whose destination the incoming instruction reads.
  assign raw_hazard = out_valid && load && (out_rd != 5'd0) && in_valid &&
                      (((out_rd == in_rs1) && d_uses_rs1) || ((out_rd == in_rs2) && d_uses_rs2));
  assign hazard     = (HAZARD_EN != 0) ? raw_hazard : 1'b0;
  assign adv        = !out_valid || ex_ready;
  assign in_ready   = adv && !hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      reg_write   <= 1'b0;
      operand_a   <= 1'b0;
      operand_b   <= 1'b0;
      load        <= 1'b0;
      store       <= 1'b0;
      branch      <= 1'b0;
      mem_en      <= 1'b0;
      next_sel    <= 1'b0;
      imm_sel     <= '0;
      mem_to_reg  <= '0;
      alu_control <= '0;
      illegal     <= 1'b0;
    end else if (flush || (adv && !(in_valid && in_ready))) begin
      // Flush or bubble: the stage empties and every control reads 0.
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      reg_write   <= 1'b0;
      operand_a   <= 1'b0;
      operand_b   <= 1'b0;
      load        <= 1'b0;
      store       <= 1'b0;
      branch      <= 1'b0;
      mem_en      <= 1'b0;
      next_sel    <= 1'b0;
      imm_sel     <= '0;
      mem_to_reg  <= '0;
      alu_control <= '0;
      illegal     <= 1'b0;
    end else if (adv) begin
      out_valid   <= 1'b1;
      out_pc      <= pc;
      out_instr   <= instr;
      out_rd      <= instr[11:7];
      out_rs1     <= in_rs1;
      out_rs2     <= in_rs2;
      reg_write   <= d_reg_write;
      operand_a   <= d_operand_a;
      operand_b   <= d_operand_b;
      load        <= d_load;
      store       <= d_store;
      branch      <= d_branch;
      mem_en      <= d_mem_en;
      next_sel    <= d_next_sel;
      imm_sel     <= d_imm_sel;
      mem_to_reg  <= d_mem_to_reg;
      alu_control <= d_alu_control;
      illegal     <= d_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (out_valid || in_valid) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe: load-use, false hazards, backpressure, flush,
// illegal decode, mid-stream reset and counter saturation (second instance, CNT_W=2).
module tb_id_ex_ctrl_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, ex_ready;
  logic [31:0] instr, pc;
  logic        in_ready, out_valid, reg_write, operand_a, operand_b, load, store, branch;
  logic        mem_en, next_sel, illegal, hazard;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  imm_sel;
  logic [1:0]  mem_to_reg;
  logic [3:0]  alu_control;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_in_ready, s_out_valid, s_reg_write, s_operand_a, s_operand_b, s_load;
  logic        s_store, s_branch, s_mem_en, s_next_sel, s_illegal, s_hazard;
  logic [31:0] s_out_pc, s_out_instr;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
  logic [2:0]  s_imm_sel;
  logic [1:0]  s_mem_to_reg;
  logic [3:0]  s_alu_control;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.XLEN(32), .HAZARD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .reg_write(reg_write), .operand_a(operand_a), .operand_b(operand_b), .load(load),
    .store(store), .branch(branch), .mem_en(mem_en), .next_sel(next_sel), .imm_sel(imm_sel),
    .mem_to_reg(mem_to_reg), .alu_control(alu_control), .illegal(illegal), .hazard(hazard),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_ctrl_pipe #(.XLEN(32), .HAZARD_EN(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr), .pc(pc),
    .flush(flush), .ex_ready(ex_ready), .out_valid(s_out_valid), .out_pc(s_out_pc),
    .out_instr(s_out_instr), .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2),
    .reg_write(s_reg_write), .operand_a(s_operand_a), .operand_b(s_operand_b), .load(s_load),
    .store(s_store), .branch(s_branch), .mem_en(s_mem_en), .next_sel(s_next_sel),
    .imm_sel(s_imm_sel), .mem_to_reg(s_mem_to_reg), .alu_control(s_alu_control),
    .illegal(s_illegal), .hazard(s_hazard), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    in_valid = v;
    instr    = i;
    pc       = p;
    #4;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    chk("reset_illegal", 32'(illegal), 0);
    rst = 1'b0;
    tick();

    // Load-use: lw x5,0(x1) then add x6,x5,x2
    drive(1'b1, 32'h0000A283, 32'h100);
    chk("lw_in_ready", 32'(in_ready), 1);
    chk("lw_hazard", 32'(hazard), 0);
    tick();
    drive(1'b1, 32'h00228333, 32'h104);
    chk("lw_out_valid", 32'(out_valid), 1);
    chk("lw_load", 32'(load), 1);
    chk("lw_mem_en", 32'(mem_en), 1);
    chk("lw_reg_write", 32'(reg_write), 1);
    chk("lw_mem_to_reg", 32'(mem_to_reg), 1);
    chk("lw_out_rd", 32'(out_rd), 5);
    chk("lw_out_pc", out_pc, 32'h100);
    chk("lu_hazard", 32'(hazard), 1);
    chk("lu_in_ready", 32'(in_ready), 0);
    tick();
    #4;
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_bubble", 32'(out_valid), 0);
    chk("lu_bubble_rw", 32'(reg_write), 0);
    chk("lu_hazard_gone", 32'(hazard), 0);
    chk("lu_in_ready_back", 32'(in_ready), 1);
    tick();
    #4;
    chk("add_out_valid", 32'(out_valid), 1);
    chk("add_reg_write", 32'(reg_write), 1);
    chk("add_rs1", 32'(out_rs1), 5);
    chk("add_rs2", 32'(out_rs2), 2);
    chk("add_rd", 32'(out_rd), 6);
    chk("add_alu", 32'(alu_control), 0);
    chk("add_operand_b", 32'(operand_b), 0);
    chk("add_stall_cnt", 32'(stall_cnt), 1);

    // No false hazard: add x6,x3,x2 after lw x5
    tick();
    drive(1'b1, 32'h0000A283, 32'h108);
    tick();
    drive(1'b1, 32'h00218333, 32'h10C);
    chk("nf_add_hazard", 32'(hazard), 0);
    chk("nf_add_in_ready", 32'(in_ready), 1);
    tick();
    #4;
    chk("nf_add_captured", out_instr, 32'h00218333);
    chk("nf_add_valid", 32'(out_valid), 1);

    // lui x7 with rs1 field 5
    tick();
    drive(1'b1, 32'h0000A283, 32'h110);
    tick();
    drive(1'b1, 32'h000283B7, 32'h114);
    chk("nf_lui_hazard", 32'(hazard), 0);
    tick();
    #4;
    chk("lui_rd", 32'(out_rd), 7);
    chk("lui_imm_sel", 32'(imm_sel), 3);
    chk("lui_alu", 32'(alu_control), 32'hF);
    chk("lui_operand_b", 32'(operand_b), 1);

    // lw x0 then add x6,x0,x2
    tick();
    drive(1'b1, 32'h0000A003, 32'h118);
    tick();
    drive(1'b1, 32'h00200333, 32'h11C);
    chk("nf_x0_hazard", 32'(hazard), 0);
    tick();

    // Backpressure: held add x6,x0,x2 with addi x1,x0,1 waiting
    ex_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h120);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_instr", out_instr, 32'h00200333);
      chk("bp_out_pc", out_pc, 32'h11C);
      tick();
      #4;
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    tick();
    #4;
    chk("bp_addi_captured", out_instr, 32'h00100093);
    chk("bp_addi_operand_b", 32'(operand_b), 1);
    chk("bp_addi_reg_write", 32'(reg_write), 1);

    // Flush with valid held and valid incoming
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h0020A223, 32'h124);
    chk("fl_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_flush_cnt", 32'(flush_cnt), 1);
    chk("fl_store_clear", 32'(store), 0);

    // Flush during hazard
    tick();
    drive(1'b1, 32'h0000A283, 32'h128);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00228333, 32'h12C);
    chk("flh_hazard", 32'(hazard), 1);
    tick();
    flush = 1'b0;
    #4;
    chk("flh_hazard_cleared", 32'(hazard), 0);
    chk("flh_out_valid", 32'(out_valid), 0);
    chk("flh_stall_cnt", 32'(stall_cnt), 2);
    chk("flh_flush_cnt", 32'(flush_cnt), 2);

    // Illegal opcode
    tick();
    drive(1'b1, 32'h00000000, 32'h130);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ill_out_valid", 32'(out_valid), 1);
    chk("ill_illegal", 32'(illegal), 1);
    chk("ill_reg_write", 32'(reg_write), 0);
    chk("ill_mem_en", 32'(mem_en), 0);
    chk("ill_load", 32'(load), 0);

    // Reset while out_valid=1 (ex_ready=0 keeps the bundle held)
    ex_ready = 1'b0;
    tick();
    drive(1'b1, 32'h0020A223, 32'h134);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_illegal", 32'(illegal), 0);
    chk("rst_mid_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_mid_flush_cnt", 32'(flush_cnt), 0);
    tick();
    rst = 1'b0;
    ex_ready = 1'b1;
    #4;
    chk("rst_post_out_valid", 32'(out_valid), 0);
    tick();
    #4;
    chk("sw_out_valid", 32'(out_valid), 1);
    chk("sw_store", 32'(store), 1);
    chk("sw_mem_en", 32'(mem_en), 1);
    chk("sw_reg_write", 32'(reg_write), 0);
    chk("sw_imm_sel", 32'(imm_sel), 1);

    // Saturation: lw x5 held under backpressure, beq x0,x5 stalled for 5 cycles
    rst = 1'b1;
    #1;
    rst = 1'b0;
    ex_ready = 1'b0;
    drive(1'b1, 32'h0000A283, 32'h200);
    tick();
    drive(1'b1, 32'h00500463, 32'h204);
    chk("sat_hazard", 32'(hazard), 1);
    chk("sat_small_hazard", 32'(s_hazard), 1);
    repeat (5) tick();
    #4;
    chk("sat_stall_small", 32'(s_stall_cnt), 3);
    chk("sat_stall_wide", 32'(stall_cnt), 5);
    ex_ready = 1'b1;
    #1;
    chk("sat_release_in_ready", 32'(in_ready), 0);
    tick();
    #4;
    chk("sat_bubble", 32'(out_valid), 0);
    chk("sat_stall_wide2", 32'(stall_cnt), 6);
    chk("sat_stall_small2", 32'(s_stall_cnt), 3);
    tick();
    #4;
    chk("beq_branch", 32'(branch), 1);
    chk("beq_imm_sel", 32'(imm_sel), 2);
    chk("beq_alu", 32'(alu_control), 32'h8);
    chk("beq_reg_write", 32'(reg_write), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
